// File: rtl/srlzr_piso.sv
// Parallel-in/serial-out shift register for the TX serializer path.
// Captures a word on iLOAD, then presents one bit per iSHIFT on srl_out.
module srlzr_piso #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] iDATA_IN,
  input  logic             iLOAD,
  input  logic             iSHIFT,
  output logic             srl_out,
  output logic             oEMPTY
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  // Strobe semantics: iLOAD and iSHIFT are single-cycle qualifiers sampled on
  // every rising edge; there is no back-pressure, and iLOAD beats iSHIFT.
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic [CW-1:0]    cnt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign sreg_shifted = {sreg[WIDTH-2:0], FILL};
      assign srl_out      = sreg[WIDTH-1];
    end else begin : g_lsb
      assign sreg_shifted = {FILL, sreg[WIDTH-1:1]};
      assign srl_out      = sreg[0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (iLOAD) begin
      sreg <= iDATA_IN;
      cnt  <= CNT_FULL;
    end else if (iSHIFT) begin
      sreg <= sreg_shifted;
      // Saturate at zero so shifting past the end of a word never wraps.
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign oEMPTY = (cnt == '0);

endmodule

// File: tb/tb_srlzr_piso.sv
// Directed bench for srlzr_piso: an MSB-first/FILL=0 and an LSB-first/FILL=1
// instance share the same stimulus and are checked against hand-derived bits.
module tb_srlzr_piso;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       load;
  logic       shift;
  logic       out_m, empty_m;
  logic       out_l, empty_l;

  int pass_cnt;
  int total_cnt;

  srlzr_piso #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .iDATA_IN(data_in), .iLOAD(load), .iSHIFT(shift),
    .srl_out(out_m), .oEMPTY(empty_m)
  );

  srlzr_piso #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .iDATA_IN(data_in), .iLOAD(load), .iSHIFT(shift),
    .srl_out(out_l), .oEMPTY(empty_l)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b1; shift = 1'b0; data_in = 8'hFF;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if ({out_m, out_l, empty_m, empty_l} !== 4'b0011)
        $display("FAIL reset_hold cyc %0d: got out_m=%b out_l=%b empty_m=%b empty_l=%b required 0 0 1 1",
                 i, out_m, out_l, empty_m, empty_l);
      else pass_cnt++;
    end
    rst = 1'b0; load = 1'b0;
    tick();
    total_cnt++;
    if ({out_m, out_l, empty_m, empty_l} !== 4'b0011)
      $display("FAIL reset_release: got out_m=%b out_l=%b empty_m=%b empty_l=%b required 0 0 1 1",
               out_m, out_l, empty_m, empty_l);
    else pass_cnt++;
  endtask

  // Load a word then shift it out continuously; MSB instance emits d[7-k],
  // LSB instance emits d[k]; after shift 8 each shows its FILL and is empty.
  task automatic test_word(input logic [7:0] d, input string name);
    logic exp_m, exp_l, exp_e;
    data_in = d; load = 1'b1; shift = 1'b0;
    tick();
    load = 1'b0; shift = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) tick();
      exp_m = (k < 8) ? d[7-k] : 1'b0;
      exp_l = (k < 8) ? d[k]   : 1'b1;
      exp_e = (k == 8);
      total_cnt++;
      if (out_m !== exp_m || out_l !== exp_l || empty_m !== exp_e || empty_l !== exp_e)
        $display("FAIL %s bit %0d: got out_m=%b out_l=%b empty_m=%b empty_l=%b required %b %b %b %b",
                 name, k, out_m, out_l, empty_m, empty_l, exp_m, exp_l, exp_e, exp_e);
      else pass_cnt++;
    end
    shift = 1'b0;
  endtask

  task automatic test_simultaneous();
    logic [7:0] d;
    d = 8'h0F;
    data_in = 8'hF0; load = 1'b1; shift = 1'b0;
    tick();
    data_in = d; load = 1'b1; shift = 1'b1;
    tick();
    total_cnt++;
    if (out_m !== 1'b0 || out_l !== 1'b1 || empty_m !== 1'b0)
      $display("FAIL simul_load: got out_m=%b out_l=%b empty_m=%b required 0 1 0",
               out_m, out_l, empty_m);
    else pass_cnt++;
    // Seven more shifts must leave data present: the counter restarted at 8.
    load = 1'b0; shift = 1'b1; data_in = 8'hAA;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total_cnt++;
      if (out_m !== ((k < 8) ? d[7-k] : 1'b0) || out_l !== ((k < 8) ? d[k] : 1'b1) ||
          empty_m !== (k == 8) || empty_l !== (k == 8))
        $display("FAIL simul_shift %0d: got out_m=%b out_l=%b empty_m=%b empty_l=%b",
                 k, out_m, out_l, empty_m, empty_l);
      else pass_cnt++;
    end
    shift = 1'b0;
  endtask

  task automatic test_gap_overshoot();
    logic [7:0] d;
    d = 8'hC3;
    data_in = d; load = 1'b1; shift = 1'b0;
    tick();
    load = 1'b0; data_in = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      shift = 1'b1;
      tick();
      shift = 1'b0;
      tick();
      tick();
      total_cnt++;
      if (out_m !== ((k < 8) ? d[7-k] : 1'b0) || out_l !== ((k < 8) ? d[k] : 1'b1) ||
          empty_m !== (k == 8))
        $display("FAIL gap_hold %0d: got out_m=%b out_l=%b empty_m=%b",
                 k, out_m, out_l, empty_m);
      else pass_cnt++;
    end
    shift = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total_cnt++;
      if ({out_m, out_l, empty_m, empty_l} !== 4'b0111)
        $display("FAIL overshoot %0d: got out_m=%b out_l=%b empty_m=%b empty_l=%b required 0 1 1 1",
                 k, out_m, out_l, empty_m, empty_l);
      else pass_cnt++;
    end
    shift = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    d = 8'h3C;
    data_in = 8'hA5; load = 1'b1; shift = 1'b0;
    tick();
    load = 1'b0; shift = 1'b1;
    for (int k = 1; k <= 7; k++) tick();
    total_cnt++;
    if (out_m !== 1'b1 || out_l !== 1'b1 || empty_m !== 1'b0)
      $display("FAIL b2b_last: got out_m=%b out_l=%b empty_m=%b required 1 1 0",
               out_m, out_l, empty_m);
    else pass_cnt++;
    data_in = d; load = 1'b1;
    tick();
    total_cnt++;
    if (out_m !== d[7] || out_l !== d[0] || empty_m !== 1'b0)
      $display("FAIL b2b_first: got out_m=%b out_l=%b empty_m=%b required %b %b 0",
               out_m, out_l, empty_m, d[7], d[0]);
    else pass_cnt++;
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      total_cnt++;
      if (out_m !== ((k < 8) ? d[7-k] : 1'b0) || out_l !== ((k < 8) ? d[k] : 1'b1) ||
          empty_m !== (k == 8))
        $display("FAIL b2b_shift %0d: got out_m=%b out_l=%b empty_m=%b",
                 k, out_m, out_l, empty_m);
      else pass_cnt++;
    end
    shift = 1'b0;
  endtask

  task automatic test_reset_mid_word();
    data_in = 8'hFF; load = 1'b1; shift = 1'b0;
    tick();
    load = 1'b0; shift = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    shift = 1'b0;
    total_cnt++;
    if (out_m !== 1'b1 || out_l !== 1'b1 || empty_m !== 1'b0)
      $display("FAIL midword_pre: got out_m=%b out_l=%b empty_m=%b required 1 1 0",
               out_m, out_l, empty_m);
    else pass_cnt++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({out_m, out_l, empty_m, empty_l} !== 4'b0011)
      $display("FAIL midword_async_rst: got out_m=%b out_l=%b empty_m=%b empty_l=%b required 0 0 1 1",
               out_m, out_l, empty_m, empty_l);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    test_word(8'h80, "after_rst_80");
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1; load = 1'b0; shift = 1'b0; data_in = 8'h00;
    test_reset();
    test_word(8'hA5, "word_a5");
    test_word(8'h01, "word_01");
    test_simultaneous();
    test_gap_overshoot();
    test_back_to_back();
    test_reset_mid_word();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
